// File: rtl/baud_tick_controller.sv
// baud_tick_controller: sequences the UART baud divisor and emits oversample, mid-bit and bit ticks.
// Optional feature macro BAUD_CUSTOM_DIV_EN: cfg_sel 7 loads cfg_div (clamped to >= 2) instead of 2604.
module baud_tick_controller #(
   parameter int OS_RATE = 16,
   parameter int DIV_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             cfg_valid,
   input  logic [2:0]       cfg_sel,
   output logic             cfg_ready,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             os_tick,
   output logic             mid_tick,
   output logic             bit_tick,
   output logic             busy,
   output logic [DIV_W-1:0] cur_div
);

   // state | meaning
   // IDLE  | counters held at 0, no ticks; accepted cfg updates cur_div directly
   // RUN   | counting with cur_div; accepted cfg is parked in pend_div
   // PEND  | counting with old cur_div until the period boundary, then swap in pend_div

   localparam int              OS_W    = $clog2(OS_RATE);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OS_RATE / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
   localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(163);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
   logic [OS_W-1:0]  os_cnt, os_cnt_nxt;
   logic [DIV_W-1:0] pend_div, pend_div_nxt;
   logic [DIV_W-1:0] cur_div_nxt;
   logic [DIV_W-1:0] sel_div;
   logic             os_tick_nxt, mid_tick_nxt, bit_tick_nxt;
   logic             cfg_accept;
   logic             period_end;

   assign cfg_ready  = (state != ST_PEND);
   assign busy       = (state != ST_IDLE);
   assign cfg_accept = cfg_valid & cfg_ready;
   assign period_end = (div_cnt == cur_div - DIV_W'(1));

   always_comb begin
      sel_div = DIV_W'(2604);
      case (cfg_sel)
         3'd0: sel_div = DIV_W'(326);
         3'd1: sel_div = DIV_W'(163);
         3'd2: sel_div = DIV_W'(81);
         3'd3: sel_div = DIV_W'(54);
         3'd4: sel_div = DIV_W'(27);
         3'd5: sel_div = DIV_W'(651);
         3'd6: sel_div = DIV_W'(1302);
`ifdef BAUD_CUSTOM_DIV_EN
         // a divisor below 2 would make os_tick stick high
         3'd7: sel_div = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
`else
         3'd7: sel_div = DIV_W'(2604);
`endif
         default: sel_div = DIV_W'(2604);
      endcase
   end

`ifndef BAUD_CUSTOM_DIV_EN
   logic unused_cfg_div;
   assign unused_cfg_div = ^cfg_div;
`endif

   always_comb begin
      state_nxt    = state;
      div_cnt_nxt  = div_cnt;
      os_cnt_nxt   = os_cnt;
      pend_div_nxt = pend_div;
      cur_div_nxt  = cur_div;
      os_tick_nxt  = 1'b0;
      mid_tick_nxt = 1'b0;
      bit_tick_nxt = 1'b0;

      // a tick due on the edge that sees run fall is still emitted once
      if (state != ST_IDLE) begin
         if (period_end) begin
            os_tick_nxt  = 1'b1;
            mid_tick_nxt = (os_cnt == OS_MID);
            bit_tick_nxt = (os_cnt == OS_LAST);
            div_cnt_nxt  = '0;
            os_cnt_nxt   = os_cnt + OS_W'(1);
         end else begin
            div_cnt_nxt  = div_cnt + DIV_W'(1);
         end
      end

      case (state)
         ST_IDLE: begin
            div_cnt_nxt = '0;
            os_cnt_nxt  = '0;
            if (cfg_accept) cur_div_nxt = sel_div;
            if (run)        state_nxt   = ST_RUN;
         end
         ST_RUN: begin
            if (!run) begin
               state_nxt   = ST_IDLE;
               div_cnt_nxt = '0;
               os_cnt_nxt  = '0;
               if (cfg_accept) cur_div_nxt = sel_div;
            end else if (cfg_accept) begin
               pend_div_nxt = sel_div;
               state_nxt    = ST_PEND;
            end
         end
         ST_PEND: begin
            if (!run) begin
               state_nxt   = ST_IDLE;
               cur_div_nxt = pend_div;
               div_cnt_nxt = '0;
               os_cnt_nxt  = '0;
            end else if (period_end) begin
               // new divisor starts a fresh bit so the phase is not skewed
               state_nxt   = ST_RUN;
               cur_div_nxt = pend_div;
               os_cnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            div_cnt_nxt = '0;
            os_cnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         os_cnt   <= '0;
         pend_div <= '0;
         cur_div  <= DIV_RESET;
         os_tick  <= 1'b0;
         mid_tick <= 1'b0;
         bit_tick <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_cnt_nxt;
         os_cnt   <= os_cnt_nxt;
         pend_div <= pend_div_nxt;
         cur_div  <= cur_div_nxt;
         os_tick  <= os_tick_nxt;
         mid_tick <= mid_tick_nxt;
         bit_tick <= bit_tick_nxt;
      end
   end

endmodule

// File: tb/tb_baud_tick_controller.sv
// Directed bench for baud_tick_controller: table of divisor selects plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_baud_tick_controller;
   logic        clk = 1'b0;
   logic        reset, run, cfg_valid, cfg_ready;
   logic [2:0]  cfg_sel;
   logic [15:0] cfg_div, cur_div;
   logic        os_tick, mid_tick, bit_tick, busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_os  = 0;
   int n_mid = 0;
   int n_bit = 0;
   logic prev_os = 1'b0;

   baud_tick_controller dut (
      .clk(clk), .reset(reset), .run(run), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
      .cfg_ready(cfg_ready), .cfg_div(cfg_div), .os_tick(os_tick), .mid_tick(mid_tick),
      .bit_tick(bit_tick), .busy(busy), .cur_div(cur_div)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (os_tick) check("os_tick_not_back_to_back", int'(prev_os), 0);
      if (mid_tick) check("mid_tick_with_os_tick", int'(os_tick), 1);
      if (bit_tick) check("bit_tick_with_os_tick", int'(os_tick), 1);
      n_os  += int'(os_tick);
      n_mid += int'(mid_tick);
      n_bit += int'(bit_tick);
      prev_os = os_tick;
   end

   // which: 0 = os_tick, 1 = mid_tick, 2 = bit_tick
   task automatic wait_sig(input int which, input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((which == 0 && os_tick) || (which == 1 && mid_tick) || (which == 2 && bit_tick)) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout waiting for tick %0d after %0d cycles", which, limit);
      end
   endtask

   task automatic start_run(output int c0);
      @(negedge clk);
      run = 1'b1;
      @(posedge clk);
      #1 c0 = cyc;
   endtask

   task automatic stop_idle();
      @(negedge clk);
      run = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic cfg_idle(input logic [2:0] sel);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_sel   = sel;
      check("cfg_ready_idle", int'(cfg_ready), 1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   typedef struct {
      logic [2:0] sel;
      int         exp_div;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int c0, t1, t2, t3, b1, b2, m1, n0, low;

      vecs[0] = '{3'd0, 326};
      vecs[1] = '{3'd1, 163};
      vecs[2] = '{3'd2, 81};
      vecs[3] = '{3'd3, 54};
      vecs[4] = '{3'd4, 27};
      vecs[5] = '{3'd5, 651};
      vecs[6] = '{3'd6, 1302};
`ifdef BAUD_CUSTOM_DIV_EN
      vecs[7] = '{3'd7, 5};
`else
      vecs[7] = '{3'd7, 2604};
`endif

      reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_sel = 3'd0; cfg_div = 16'd5;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_cur_div", int'(cur_div), 163);
      check("reset_cfg_ready", int'(cfg_ready), 1);
      check("reset_busy", int'(busy), 0);
      n0 = n_os + n_mid + n_bit;
      repeat (1000) @(negedge clk);
      check("idle_no_ticks", n_os + n_mid + n_bit - n0, 0);

      // default divisor: os period 163, mid at 1304, bit every 2608
      start_run(c0);
      check("run_busy", int'(busy), 1);
      wait_sig(0, 200, t1);
      check("default_first_os", t1 - c0, 163);
      wait_sig(0, 200, t2);
      check("default_os_period", t2 - t1, 163);
      wait_sig(1, 1400, m1);
      check("default_first_mid", m1 - c0, 1304);
      wait_sig(2, 2700, b1);
      check("default_first_bit", b1 - c0, 2608);
      wait_sig(2, 2700, b2);
      check("default_bit_period", b2 - b1, 2608);
      stop_idle();

      // divisor table
      for (int i = 0; i < 8; i++) begin
         cfg_idle(vecs[i].sel);
         check($sformatf("table_cur_div_sel%0d", i), int'(cur_div), vecs[i].exp_div);
         start_run(c0);
         wait_sig(0, vecs[i].exp_div + 5, t1);
         check($sformatf("table_first_os_sel%0d", i), t1 - c0, vecs[i].exp_div);
         wait_sig(0, vecs[i].exp_div + 5, t2);
         check($sformatf("table_os_period_sel%0d", i), t2 - t1, vecs[i].exp_div);
         stop_idle();
      end

      // run and cfg on the same edge: new divisor governs the first period
      cfg_idle(3'd1);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_sel = 3'd4; run = 1'b1;
      @(posedge clk);
      #1 c0 = cyc;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("same_edge_cur_div", int'(cur_div), 27);
      wait_sig(0, 40, t1);
      check("same_edge_first_os", t1 - c0, 27);
      wait_sig(2, 500, b1);
      wait_sig(2, 500, b2);
      check("sel4_bit_period", b2 - b1, 432);
      stop_idle();

      // divisor change mid-period while running
      cfg_idle(3'd1);
      start_run(c0);
      wait_sig(0, 200, t1);
      repeat (50) @(negedge clk);
      cfg_valid = 1'b1; cfg_sel = 3'd2;
      check("pend_ready_before", int'(cfg_ready), 1);
      low = 0; t2 = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 0) cfg_valid = 1'b0;
         if (os_tick) begin
            t2 = cyc;
            break;
         end
         if (!cfg_ready) low++;
      end
      check("pend_boundary_found", int'(t2 >= 0), 1);
      check("pend_ready_low_cycles", low, 112);
      check("pend_old_period_kept", t2 - t1, 163);
      check("pend_ready_after", int'(cfg_ready), 1);
      check("pend_cur_div_after", int'(cur_div), 81);
      wait_sig(0, 100, t3);
      check("pend_new_period", t3 - t2, 81);
      wait_sig(2, 1400, b1);
      check("pend_bit_after_restart", b1 - t2, 1296);
      stop_idle();

      // run dropped mid-period then re-asserted
      cfg_idle(3'd1);
      start_run(c0);
      wait_sig(0, 200, t1);
      repeat (40) @(negedge clk);
      run = 1'b0;
      n0 = n_os;
      repeat (10) @(negedge clk);
      check("halt_no_ticks", n_os - n0, 0);
      check("halt_busy", int'(busy), 0);
      start_run(c0);
      wait_sig(0, 200, t1);
      check("restart_first_os", t1 - c0, 163);

      // run falls while a change is pending: divisor applied at once
      @(negedge clk);
      cfg_valid = 1'b1; cfg_sel = 3'd3;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("pend_drop_ready_low", int'(cfg_ready), 0);
      check("pend_drop_old_div", int'(cur_div), 163);
      run = 1'b0;
      @(negedge clk);
      check("pend_drop_cur_div", int'(cur_div), 54);
      check("pend_drop_busy", int'(busy), 0);
      check("pend_drop_ready", int'(cfg_ready), 1);

      // reset during PEND discards the pending divisor
      start_run(c0);
      repeat (10) @(negedge clk);
      cfg_valid = 1'b1; cfg_sel = 3'd4;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("rst_pend_ready_low", int'(cfg_ready), 0);
      reset = 1'b1; run = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pend_cur_div", int'(cur_div), 163);
      check("rst_pend_ready", int'(cfg_ready), 1);
      check("rst_pend_busy", int'(busy), 0);
      reset = 1'b0;
      start_run(c0);
      wait_sig(0, 200, t1);
      check("rst_pend_first_os", t1 - c0, 163);
      wait_sig(0, 200, t2);
      check("rst_pend_os_period", t2 - t1, 163);
      stop_idle();

`ifdef BAUD_CUSTOM_DIV_EN
      cfg_div = 16'd0;
      cfg_idle(3'd7);
      check("custom_clamp_cur_div", int'(cur_div), 2);
      start_run(c0);
      wait_sig(0, 10, t1);
      check("custom_clamp_first_os", t1 - c0, 2);
      wait_sig(0, 10, t2);
      check("custom_clamp_period", t2 - t1, 2);
      stop_idle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
